// File: rtl/i2c_master_xfer_seq_pkg.sv
// -----------------------------------------------------------------------------
// i2c_master_xfer_seq_pkg
// Shared definitions for the I2C transfer sequencer:
//   - CMD_* byte-controller command codes (same codes the byte controller
//     decodes)
//   - state_e : sequencer state encoding
//   - addr_byte() : builds the on-wire address byte {addr, rw}
// -----------------------------------------------------------------------------
package i2c_master_xfer_seq_pkg;

  localparam logic [3:0] CMD_IDLE    = 4'h0;
  localparam logic [3:0] CMD_START   = 4'h1;
  localparam logic [3:0] CMD_RESTART = 4'h2;
  localparam logic [3:0] CMD_STOP    = 4'h3;
  localparam logic [3:0] CMD_WRITE   = 4'h4;
  localparam logic [3:0] CMD_READ    = 4'h5;
  localparam logic [3:0] CMD_RD_ACK  = 4'h6;
  localparam logic [3:0] CMD_WR_ACK  = 4'h7;
  localparam logic [3:0] CMD_WR_NAK  = 4'h8;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_ADDR     = 4'd2,
    ST_ADDR_ACK = 4'd3,
    ST_WWAIT    = 4'd4,
    ST_WBYTE    = 4'd5,
    ST_WACK     = 4'd6,
    ST_RBYTE    = 4'd7,
    ST_RACK     = 4'd8,
    ST_STOP     = 4'd9
  } state_e;

  function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
    return {addr, rw};
  endfunction

endpackage

// File: rtl/i2c_master_xfer_seq.sv
// -----------------------------------------------------------------------------
// i2c_master_xfer_seq
// Turns one transfer request (7-bit address, direction, byte count) into the
// byte-level command stream for an I2C byte controller, moves payload bytes
// over valid/ready handshakes and reports NAK / arbitration loss / completion.
//
// Optional feature macro: I2C_XFER_REPSTART_EN
//   defined   : adds i_hold; a held transfer ends with CMD_RESTART and the
//               next transfer skips the START command.
//   undefined : every transfer ends with CMD_STOP.
//
// Ports
//   i_sysclk, i_nReset      clock, synchronous active-low reset
//   i_enable                low = synchronous clear
//   i_start/i_addr/i_rw/i_len   transfer request
//   i_wdata/i_wvalid/o_wready   write payload handshake
//   o_rdata/o_rvalid            read payload (no backpressure)
//   o_busy/o_done/o_nak/o_al    host status
//   o_cmd_trig/o_cmd/o_data     command to byte controller
//   i_cmd_ack/i_i2c_ack/i_i2c_al/i_data   byte controller response
// -----------------------------------------------------------------------------
module i2c_master_xfer_seq
  import i2c_master_xfer_seq_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             i_sysclk,
  input  logic             i_nReset,
  input  logic             i_enable,
  input  logic             i_start,
  input  logic [6:0]       i_addr,
  input  logic             i_rw,
  input  logic [LEN_W-1:0] i_len,
`ifdef I2C_XFER_REPSTART_EN
  input  logic             i_hold,
`endif
  input  logic [7:0]       i_wdata,
  input  logic             i_wvalid,
  output logic             o_wready,
  output logic [7:0]       o_rdata,
  output logic             o_rvalid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_nak,
  output logic             o_al,
  output logic             o_cmd_trig,
  output logic [3:0]       o_cmd,
  output logic [7:0]       o_data,
  input  logic             i_cmd_ack,
  input  logic             i_i2c_ack,
  input  logic             i_i2c_al,
  input  logic [7:0]       i_data
);

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic             rw_q;
  logic             hold_q;
  logic             owned_q;   // previous transfer ended with RESTART
  logic             wready_q;
  logic [7:0]       rdata_q;
  logic             rvalid_q;
  logic             busy_q;
  logic             done_q;
  logic             nak_q;
  logic             al_q;
  logic             cmd_trig_q;
  logic [3:0]       cmd_q;
  logic [7:0]       data_q;

  logic [LEN_W-1:0] cnt_dec_d;
  logic [3:0]       end_cmd_d;

  // Saturating decrement of the remaining-byte counter (never wraps below 0).
  always_comb begin
    cnt_dec_d = cnt_q;
    if (cnt_q != CNT_ZERO) begin
      cnt_dec_d = cnt_q - CNT_ONE;
    end else begin
      cnt_dec_d = CNT_ZERO;
    end
  end

  // Closing command of a transfer that was not NAKed.
  always_comb begin
    end_cmd_d = CMD_STOP;
    if (hold_q) begin
      end_cmd_d = CMD_RESTART;
    end else begin
      end_cmd_d = CMD_STOP;
    end
  end

  // Sequencer FSM with all host and byte-controller outputs registered.
  // Commands are launched on the transition edge so o_cmd_trig is high in
  // the first cycle of the new state.
  always_ff @(posedge i_sysclk) begin
    if (!i_nReset || !i_enable) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      rw_q       <= 1'b0;
      hold_q     <= 1'b0;
      owned_q    <= 1'b0;
      wready_q   <= 1'b0;
      rdata_q    <= 8'hff;
      rvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nak_q      <= 1'b0;
      al_q       <= 1'b0;
      cmd_trig_q <= 1'b0;
      cmd_q      <= CMD_IDLE;
      data_q     <= 8'hff;
    end else begin
      cmd_trig_q <= 1'b0;
      rvalid_q   <= 1'b0;
      done_q     <= 1'b0;
      wready_q   <= 1'b0;
      if ((state_q != ST_IDLE) && i_i2c_al) begin
        // Arbitration loss: abandon the bus without STOP; beats a same-cycle ack.
        al_q    <= 1'b1;
        done_q  <= 1'b1;
        state_q <= ST_IDLE;
        cmd_q   <= CMD_IDLE;
        owned_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            busy_q <= 1'b0;
            // busy_q is still high in the o_done cycle, so a start there is ignored.
            if (i_start && !busy_q) begin
              rw_q       <= i_rw;
              cnt_q      <= i_len;
`ifdef I2C_XFER_REPSTART_EN
              hold_q     <= i_hold;
`else
              hold_q     <= 1'b0;
`endif
              data_q     <= addr_byte(i_addr, i_rw);
              nak_q      <= 1'b0;
              al_q       <= 1'b0;
              busy_q     <= 1'b1;
              cmd_trig_q <= 1'b1;
              if (owned_q) begin
                state_q <= ST_ADDR;
                cmd_q   <= CMD_WRITE;
              end else begin
                state_q <= ST_START;
                cmd_q   <= CMD_START;
              end
            end
          end
          ST_START: begin
            if (i_cmd_ack) begin
              state_q    <= ST_ADDR;
              cmd_q      <= CMD_WRITE;
              cmd_trig_q <= 1'b1;
            end
          end
          ST_ADDR: begin
            if (i_cmd_ack) begin
              state_q    <= ST_ADDR_ACK;
              cmd_q      <= CMD_RD_ACK;
              cmd_trig_q <= 1'b1;
            end
          end
          ST_ADDR_ACK: begin
            if (i_cmd_ack) begin
              if (i_i2c_ack) begin
                nak_q      <= 1'b1;
                state_q    <= ST_STOP;
                cmd_q      <= CMD_STOP;
                cmd_trig_q <= 1'b1;
              end else if (cnt_q == CNT_ZERO) begin
                state_q    <= ST_STOP;
                cmd_q      <= end_cmd_d;
                cmd_trig_q <= 1'b1;
              end else if (!rw_q) begin
                state_q  <= ST_WWAIT;
                wready_q <= 1'b1;
              end else begin
                state_q    <= ST_RBYTE;
                cmd_q      <= CMD_READ;
                cmd_trig_q <= 1'b1;
              end
            end
          end
          ST_WWAIT: begin
            if (i_wvalid && wready_q) begin
              data_q     <= i_wdata;
              state_q    <= ST_WBYTE;
              cmd_q      <= CMD_WRITE;
              cmd_trig_q <= 1'b1;
            end else begin
              wready_q <= 1'b1;
            end
          end
          ST_WBYTE: begin
            if (i_cmd_ack) begin
              state_q    <= ST_WACK;
              cmd_q      <= CMD_RD_ACK;
              cmd_trig_q <= 1'b1;
            end
          end
          ST_WACK: begin
            if (i_cmd_ack) begin
              cnt_q <= cnt_dec_d;
              if (i_i2c_ack) begin
                nak_q      <= 1'b1;
                state_q    <= ST_STOP;
                cmd_q      <= CMD_STOP;
                cmd_trig_q <= 1'b1;
              end else if (cnt_q <= CNT_ONE) begin
                state_q    <= ST_STOP;
                cmd_q      <= end_cmd_d;
                cmd_trig_q <= 1'b1;
              end else begin
                state_q  <= ST_WWAIT;
                wready_q <= 1'b1;
              end
            end
          end
          ST_RBYTE: begin
            if (i_cmd_ack) begin
              rdata_q    <= i_data;
              rvalid_q   <= 1'b1;
              state_q    <= ST_RACK;
              cmd_trig_q <= 1'b1;
              // Master NAKs the final byte so the slave releases SDA.
              if (cnt_q <= CNT_ONE) begin
                cmd_q <= CMD_WR_NAK;
              end else begin
                cmd_q <= CMD_WR_ACK;
              end
            end
          end
          ST_RACK: begin
            if (i_cmd_ack) begin
              cnt_q      <= cnt_dec_d;
              cmd_trig_q <= 1'b1;
              if (cnt_q <= CNT_ONE) begin
                state_q <= ST_STOP;
                cmd_q   <= end_cmd_d;
              end else begin
                state_q <= ST_RBYTE;
                cmd_q   <= CMD_READ;
              end
            end
          end
          ST_STOP: begin
            if (i_cmd_ack) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
              owned_q <= (cmd_q == CMD_RESTART);
              cmd_q   <= CMD_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_IDLE;
          end
        endcase
      end
    end
  end

  assign o_wready   = wready_q;
  assign o_rdata    = rdata_q;
  assign o_rvalid   = rvalid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_nak      = nak_q;
  assign o_al       = al_q;
  assign o_cmd_trig = cmd_trig_q;
  assign o_cmd      = cmd_q;
  assign o_data     = data_q;

endmodule
